bcd_count_ctrl: RTL and testbench
=================================

BCD_COUNT_CTRL -- requirements
Module: bcd_count_ctrl

Interface
REQ-001 Parameter: DEFAULT_LIMIT, 8'h99, power-up/reset terminal value, two BCD digits {tens,ones}.
REQ-002 Ports:
  CLK  in  1  single clock, rising edge.
  Clear  in  1  synchronous, active-high reset.
  cmd_valid  in  1  command offered.
  cmd_ready  out  1  command accepted when valid&ready at CLK edge.
  cmd_op  in  2  00 START, 01 STOP, 10 PRESET, 11 SET_LIMIT.
  cmd_data  in  8  BCD {tens,ones} for PRESET/SET_LIMIT.
  tick  in  1  count-request strobe, any rate up to every cycle.
  wrap_mode  in  1  1: reload 00 at limit; 0: stop at limit.
  cnt_a  in  4  counter ones digit feedback.
  cnt_b  in  4  counter tens digit feedback.
  cnt_en  out  1  count enable to two-digit counter.
  cnt_load  out  1  load strobe to counter.
  load_a  out  4  ones digit load value.
  load_b  out  4  tens digit load value.
  cnt_clear_b  out  1  active-low counter clear.
  running  out  1  high in RUN.
  done  out  1  one-cycle pulse on reaching limit (stop mode).
  wrapped  out  1  one-cycle pulse on limit reload (wrap mode).

Function
REQ-003 FSM states IDLE, RUN, LOAD, DONE; LOAD carries a registered return state (IDLE or RUN).
REQ-004 at_limit = ({cnt_b,cnt_a} == limit register); equality only, no magnitude compare.
REQ-005 cnt_en combinational = (state==RUN) & tick & ~at_limit & ~(cmd accepted with op STOP or PRESET); counter advances on that same edge.
REQ-006 cmd_ready = 0 in LOAD and during Clear; 1 otherwise.
REQ-007 Command precedence in any cycle: accepted command over tick; tick dropped when STOP/PRESET accepted.
REQ-008 IDLE: START->RUN; PRESET->LOAD(ret IDLE); STOP no effect; SET_LIMIT stays IDLE.
REQ-009 RUN: STOP->IDLE; PRESET->LOAD(ret RUN); START no effect; SET_LIMIT updates limit, same-cycle tick uses old limit.
REQ-010 RUN, tick & at_limit, no STOP/PRESET: wrap_mode=1 -> LOAD 00 (ret RUN), wrapped pulse next cycle; wrap_mode=0 -> DONE, done pulse next cycle.
REQ-011 LOAD lasts exactly one cycle: cnt_load=1, load_a/load_b driven with target value, ticks ignored, then return state.
REQ-012 DONE: START->LOAD 00 (ret RUN); PRESET->LOAD(ret IDLE); STOP->IDLE; ticks ignored; done not repeated.
REQ-013 BCD sanitise: any cmd_data nibble >9 is saturated to 9 before use for PRESET or SET_LIMIT.
REQ-014 Preset above limit: counting continues through 99->00 (counter's own rollover) until equality; no error.
REQ-015 load_a/load_b hold last load value outside LOAD; cnt_load otherwise 0.
REQ-016 wrap_mode sampled at the limit event only; changes mid-run take effect at next limit.

Reset
REQ-017 Clear synchronous: on edge with Clear=1, state IDLE, limit=DEFAULT_LIMIT, load_a/load_b=0, done/wrapped/running/cnt_load=0.
REQ-018 cnt_clear_b = ~Clear combinationally, so the counter is held at 00 throughout reset.
REQ-019 Clear mid-LOAD or mid-RUN aborts without cnt_load or done/wrapped pulse; pending command discarded.

Structure
REQ-020 Shared package holds state encoding and cmd_op constants (CMD_START, CMD_STOP, CMD_PRESET, CMD_SET_LIMIT).
REQ-021 One sub-module: bcd_limit_cmp (sanitise + equality compare); counter itself stays external, driven via cnt_* ports.

Verification
REQ-022 Reset, START, tick every cycle, limit 99 default, wrap_mode=0 -> cnt_en 99 times, 100th tick at 99 -> done pulse, state DONE, cnt_en low.
REQ-023 SET_LIMIT 8'h12, wrap_mode=1, START, continuous tick -> at count 12 one-cycle cnt_load with load 00, wrapped pulse, counting resumes 00->01.
REQ-024 PRESET 8'h3C in IDLE -> cnt_load one cycle with load_b=3, load_a=9; cmd_ready low that cycle; state IDLE after.
REQ-025 RUN, same cycle STOP accepted and tick high -> cnt_en=0, next state IDLE, running=0.
REQ-026 Clear asserted during LOAD -> cnt_clear_b=0, no cnt_load next cycle, state IDLE, limit back to 99.
REQ-027 DONE then START -> LOAD 00 then RUN; first tick after -> cnt_en=1.

Source files
------------

// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the two-digit BCD counter controller: FSM encoding,
// command opcodes and the BCD nibble saturation helper.
package bcd_count_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] CMD_START     = 2'b00;
    localparam logic [1:0] CMD_STOP      = 2'b01;
    localparam logic [1:0] CMD_PRESET    = 2'b10;
    localparam logic [1:0] CMD_SET_LIMIT = 2'b11;

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Command channel of the BCD counter controller: valid/ready handshake
// carrying an opcode and a two-digit BCD payload.
interface bcd_count_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/bcd_count_ctrl_limit_cmp.sv
// Sanitises command data to legal BCD and compares the external counter
// value against the terminal limit (equality only).
module bcd_limit_cmp
    import bcd_count_ctrl_pkg::*;
(
    input  logic [7:0] i_data,
    input  logic [3:0] i_cnt_a,
    input  logic [3:0] i_cnt_b,
    input  logic [7:0] i_limit,
    output logic [7:0] o_data_sat,
    output logic       o_at_limit
);
    assign o_data_sat = {bcd_sat(i_data[7:4]), bcd_sat(i_data[3:0])};
    assign o_at_limit = ({i_cnt_b, i_cnt_a} == i_limit);
endmodule

// File: rtl/bcd_count_ctrl.sv
// Controller for an external two-digit BCD counter: command-driven
// start/stop/preset, terminal limit detection with stop or wrap behaviour.
module bcd_count_ctrl
    import bcd_count_ctrl_pkg::*;
#(
    parameter logic [7:0] DEFAULT_LIMIT = 8'h99
) (
    input  logic             CLK,
    input  logic             Clear,
    bcd_count_ctrl_if.slave  cmd,
    input  logic             tick,
    input  logic             wrap_mode,
    input  logic [3:0]       cnt_a,
    input  logic [3:0]       cnt_b,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [3:0]       load_a,
    output logic [3:0]       load_b,
    output logic             cnt_clear_b,
    output logic             running,
    output logic             done,
    output logic             wrapped
);
    state_e     r_state, w_state_nxt;
    state_e     r_ret, w_ret_nxt;
    logic [7:0] r_limit, w_limit_nxt;
    logic [7:0] r_load_val, w_load_nxt;
    logic       r_done, w_done_nxt;
    logic       r_wrapped, w_wrapped_nxt;

    logic [7:0] w_data_sat;
    logic       w_at_limit;
    logic       w_acc, w_start, w_stop, w_preset, w_setlim, w_abort;

    bcd_limit_cmp u_cmp (
        .i_data     (cmd.cmd_data),
        .i_cnt_a    (cnt_a),
        .i_cnt_b    (cnt_b),
        .i_limit    (r_limit),
        .o_data_sat (w_data_sat),
        .o_at_limit (w_at_limit)
    );

    assign cmd.cmd_ready = (r_state != ST_LOAD) & ~Clear;
    assign w_acc    = cmd.cmd_valid & cmd.cmd_ready;
    assign w_start  = w_acc & (cmd.cmd_op == CMD_START);
    assign w_stop   = w_acc & (cmd.cmd_op == CMD_STOP);
    assign w_preset = w_acc & (cmd.cmd_op == CMD_PRESET);
    assign w_setlim = w_acc & (cmd.cmd_op == CMD_SET_LIMIT);
    // STOP/PRESET win over a same-cycle tick so the counter never moves under them
    assign w_abort  = w_stop | w_preset;

    assign cnt_en      = (r_state == ST_RUN) & tick & ~w_at_limit & ~w_abort;
    assign cnt_load    = (r_state == ST_LOAD);
    assign load_a      = r_load_val[3:0];
    assign load_b      = r_load_val[7:4];
    assign cnt_clear_b = ~Clear;
    assign running     = (r_state == ST_RUN);
    assign done        = r_done;
    assign wrapped     = r_wrapped;

    always_comb begin
        w_state_nxt   = r_state;
        w_ret_nxt     = r_ret;
        w_limit_nxt   = r_limit;
        w_load_nxt    = r_load_val;
        w_done_nxt    = 1'b0;
        w_wrapped_nxt = 1'b0;
        // limit compare this cycle still uses the old register value
        if (w_setlim) w_limit_nxt = w_data_sat;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_RUN;
                end else if (w_preset) begin
                    w_state_nxt = ST_LOAD;
                    w_ret_nxt   = ST_IDLE;
                    w_load_nxt  = w_data_sat;
                end
            end
            ST_RUN: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_preset) begin
                    w_state_nxt = ST_LOAD;
                    w_ret_nxt   = ST_RUN;
                    w_load_nxt  = w_data_sat;
                end else if (tick && w_at_limit) begin
                    if (wrap_mode) begin
                        w_state_nxt   = ST_LOAD;
                        w_ret_nxt     = ST_RUN;
                        w_load_nxt    = 8'h00;
                        w_wrapped_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_LOAD: w_state_nxt = r_ret;
            ST_DONE: begin
                if (w_start) begin
                    w_state_nxt = ST_LOAD;
                    w_ret_nxt   = ST_RUN;
                    w_load_nxt  = 8'h00;
                end else if (w_preset) begin
                    w_state_nxt = ST_LOAD;
                    w_ret_nxt   = ST_IDLE;
                    w_load_nxt  = w_data_sat;
                end else if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            r_state    <= ST_IDLE;
            r_ret      <= ST_IDLE;
            r_limit    <= DEFAULT_LIMIT;
            r_load_val <= 8'h00;
            r_done     <= 1'b0;
            r_wrapped  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret      <= w_ret_nxt;
            r_limit    <= w_limit_nxt;
            r_load_val <= w_load_nxt;
            r_done     <= w_done_nxt;
            r_wrapped  <= w_wrapped_nxt;
        end
    end
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: behavioural BCD counter on the cnt_* ports and a
// queue of expected counter values checked one edge after each enabled tick.
module tb_bcd_count_ctrl;
    import bcd_count_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       Clear = 1'b1;
    logic       tick = 1'b0;
    logic       wrap_mode = 1'b0;
    logic [3:0] cnt_a, cnt_b;
    logic       cnt_en, cnt_load, cnt_clear_b, running, done, wrapped;
    logic [3:0] load_a, load_b;
    logic [7:0] r_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    bcd_count_ctrl_if cif();

    bcd_count_ctrl #(.DEFAULT_LIMIT(8'h99)) dut (
        .CLK(CLK), .Clear(Clear), .cmd(cif), .tick(tick), .wrap_mode(wrap_mode),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_en(cnt_en), .cnt_load(cnt_load),
        .load_a(load_a), .load_b(load_b), .cnt_clear_b(cnt_clear_b),
        .running(running), .done(done), .wrapped(wrapped)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] to_bcd(input int d);
        logic [3:0] t, o;
        t = 4'(d / 10);
        o = 4'(d % 10);
        return {t, o};
    endfunction

    // external two-digit counter the controller drives
    always_ff @(posedge CLK) begin
        if (!cnt_clear_b)  r_cnt <= 8'h00;
        else if (cnt_load) r_cnt <= {load_b, load_a};
        else if (cnt_en)   r_cnt <= (r_cnt[3:0] == 4'd9) ?
                                    {((r_cnt[7:4] == 4'd9) ? 4'd0 : r_cnt[7:4] + 4'd1), 4'd0} :
                                    {r_cnt[7:4], r_cnt[3:0] + 4'd1};
    end
    assign cnt_a = r_cnt[3:0];
    assign cnt_b = r_cnt[7:4];

    task automatic set_in(input logic v, input logic [1:0] op, input logic [7:0] d, input logic tk);
        @(negedge CLK);
        cif.cmd_valid = v;
        cif.cmd_op    = op;
        cif.cmd_data  = d;
        tick          = tk;
        #1;
    endtask

    task automatic apply_clear();
        @(negedge CLK);
        Clear = 1'b1; cif.cmd_valid = 1'b0; tick = 1'b0;
        @(negedge CLK);
        Clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK); #1;
        checks++; if (cnt_clear_b !== 1'b0) begin errors++; $display("FAIL reset_clear_b got %b want 0", cnt_clear_b); end
        checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cif.cmd_ready); end
        @(negedge CLK); Clear = 1'b0; #1;
        checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rel got %b want 1", cif.cmd_ready); end
        checks++; if ({cnt_clear_b, running, cnt_load, done, wrapped} !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b want 10000", {cnt_clear_b, running, cnt_load, done, wrapped}); end
        checks++; if ({load_b, load_a, cnt_b, cnt_a} !== 16'h0000) begin
            errors++; $display("FAIL reset_vals got %h want 0000", {load_b, load_a, cnt_b, cnt_a}); end
    endtask

    task automatic test_stop_mode();
        int exp_dec = 0, en_cnt = 0, ticks = 0;
        logic seen = 1'b0;
        logic [7:0] e;
        wrap_mode = 1'b0;
        set_in(1'b1, CMD_START, 8'h00, 1'b0);
        for (int i = 0; i < 300; i++) begin
            set_in(1'b0, CMD_START, 8'h00, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({cnt_b, cnt_a} !== e) begin errors++; $display("FAIL stop_count got %h want %h", {cnt_b, cnt_a}, e); end
            end
            if (done) begin seen = 1'b1; break; end
            ticks++;
            if (cnt_en) begin en_cnt++; exp_dec = (exp_dec + 1) % 100; exp_q.push_back(to_bcd(exp_dec)); end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL stop_done_seen got %b want 1", seen); end
        checks++; if (en_cnt != 99) begin errors++; $display("FAIL stop_en_cnt got %0d want 99", en_cnt); end
        checks++; if (ticks != 100) begin errors++; $display("FAIL stop_ticks got %0d want 100", ticks); end
        checks++; if ({running, cnt_en} !== 2'b00) begin errors++; $display("FAIL stop_in_done got %b want 00", {running, cnt_en}); end
        checks++; if ({cnt_b, cnt_a} !== 8'h99) begin errors++; $display("FAIL stop_final got %h want 99", {cnt_b, cnt_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({done, cnt_en} !== 2'b00) begin errors++; $display("FAIL done_repeat got %b want 00", {done, cnt_en}); end
    endtask

    task automatic test_done_restart();
        set_in(1'b1, CMD_START, 8'h00, 1'b1);
        checks++; if ({cnt_en, cif.cmd_ready} !== 2'b01) begin errors++; $display("FAIL restart_in_done got %b want 01", {cnt_en, cif.cmd_ready}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({cnt_load, cif.cmd_ready, cnt_en, running} !== 4'b1000) begin
            errors++; $display("FAIL restart_load got %b want 1000", {cnt_load, cif.cmd_ready, cnt_en, running}); end
        checks++; if ({load_b, load_a} !== 8'h00) begin errors++; $display("FAIL restart_loadval got %h want 00", {load_b, load_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({running, cnt_en, cnt_load} !== 3'b110) begin errors++; $display("FAIL restart_run got %b want 110", {running, cnt_en, cnt_load}); end
        checks++; if ({cnt_b, cnt_a} !== 8'h00) begin errors++; $display("FAIL restart_cnt got %h want 00", {cnt_b, cnt_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        checks++; if ({cnt_b, cnt_a} !== 8'h01) begin errors++; $display("FAIL restart_first got %h want 01", {cnt_b, cnt_a}); end
    endtask

    task automatic test_stop_tick();
        set_in(1'b1, CMD_STOP, 8'h00, 1'b1);
        checks++; if ({cnt_en, running} !== 2'b01) begin errors++; $display("FAIL stoptick_en got %b want 01", {cnt_en, running}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({running, cnt_en} !== 2'b00) begin errors++; $display("FAIL stoptick_idle got %b want 00", {running, cnt_en}); end
        checks++; if ({cnt_b, cnt_a} !== 8'h01) begin errors++; $display("FAIL stoptick_cnt got %h want 01", {cnt_b, cnt_a}); end
    endtask

    task automatic test_wrap();
        int exp_dec = 0;
        logic seen = 1'b0;
        logic [7:0] e;
        apply_clear();
        wrap_mode = 1'b1;
        set_in(1'b1, CMD_SET_LIMIT, 8'h12, 1'b0);
        set_in(1'b1, CMD_START, 8'h00, 1'b0);
        for (int i = 0; i < 50; i++) begin
            set_in(1'b0, CMD_START, 8'h00, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({cnt_b, cnt_a} !== e) begin errors++; $display("FAIL wrap_count got %h want %h", {cnt_b, cnt_a}, e); end
            end
            if (cnt_load) begin seen = 1'b1; break; end
            if (cnt_en) begin exp_dec++; exp_q.push_back(to_bcd(exp_dec)); end
        end
        checks++; if (seen !== 1'b1 || exp_dec != 12) begin errors++; $display("FAIL wrap_reach got %b/%0d want 1/12", seen, exp_dec); end
        checks++; if ({wrapped, cnt_en, cif.cmd_ready, load_b, load_a} !== 11'b100_0000_0000) begin
            errors++; $display("FAIL wrap_load got %b want 10000000000", {wrapped, cnt_en, cif.cmd_ready, load_b, load_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({wrapped, cnt_load, running, cnt_en} !== 4'b0011) begin
            errors++; $display("FAIL wrap_after got %b want 0011", {wrapped, cnt_load, running, cnt_en}); end
        checks++; if ({cnt_b, cnt_a} !== 8'h00) begin errors++; $display("FAIL wrap_zero got %h want 00", {cnt_b, cnt_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        checks++; if ({cnt_b, cnt_a} !== 8'h01) begin errors++; $display("FAIL wrap_resume got %h want 01", {cnt_b, cnt_a}); end
    endtask

    task automatic test_preset();
        apply_clear();
        set_in(1'b1, CMD_PRESET, 8'h3C, 1'b0);
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        checks++; if ({cnt_load, cif.cmd_ready, running} !== 3'b100) begin
            errors++; $display("FAIL preset_load got %b want 100", {cnt_load, cif.cmd_ready, running}); end
        checks++; if ({load_b, load_a} !== 8'h39) begin errors++; $display("FAIL preset_val got %h want 39", {load_b, load_a}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        checks++; if ({cnt_load, cif.cmd_ready, running} !== 3'b010) begin
            errors++; $display("FAIL preset_after got %b want 010", {cnt_load, cif.cmd_ready, running}); end
        checks++; if ({cnt_b, cnt_a, load_b, load_a} !== 16'h3939) begin
            errors++; $display("FAIL preset_hold got %h want 3939", {cnt_b, cnt_a, load_b, load_a}); end
    endtask

    task automatic test_sanitise_limit();
        int exp_dec = 5, en_cnt = 0;
        logic seen = 1'b0;
        logic [7:0] e;
        wrap_mode = 1'b0;
        set_in(1'b1, CMD_SET_LIMIT, 8'h0E, 1'b0);
        set_in(1'b1, CMD_PRESET, 8'h05, 1'b0);
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        set_in(1'b1, CMD_START, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) begin
            set_in(1'b0, CMD_START, 8'h00, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++; if ({cnt_b, cnt_a} !== e) begin errors++; $display("FAIL sat_count got %h want %h", {cnt_b, cnt_a}, e); end
            end
            if (done) begin seen = 1'b1; break; end
            if (cnt_en) begin en_cnt++; exp_dec++; exp_q.push_back(to_bcd(exp_dec)); end
        end
        checks++; if (seen !== 1'b1 || en_cnt != 4) begin errors++; $display("FAIL sat_limit got %b/%0d want 1/4", seen, en_cnt); end
        checks++; if ({cnt_b, cnt_a} !== 8'h09) begin errors++; $display("FAIL sat_final got %h want 09", {cnt_b, cnt_a}); end
    endtask

    task automatic test_clear_in_load();
        apply_clear();
        set_in(1'b1, CMD_SET_LIMIT, 8'h05, 1'b0);
        set_in(1'b1, CMD_PRESET, 8'h42, 1'b0);
        @(negedge CLK);
        cif.cmd_valid = 1'b0; Clear = 1'b1;
        #1;
        checks++; if ({cnt_load, cnt_clear_b, cif.cmd_ready} !== 3'b100) begin
            errors++; $display("FAIL clrload_during got %b want 100", {cnt_load, cnt_clear_b, cif.cmd_ready}); end
        @(negedge CLK);
        Clear = 1'b0;
        #1;
        checks++; if ({cnt_load, running, load_b, load_a, cnt_b, cnt_a} !== 18'h0) begin
            errors++; $display("FAIL clrload_after got %h want 0", {cnt_load, running, load_b, load_a, cnt_b, cnt_a}); end
        wrap_mode = 1'b0;
        set_in(1'b1, CMD_PRESET, 8'h98, 1'b0);
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        set_in(1'b1, CMD_START, 8'h00, 1'b0);
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL clrload_lim98 got %b want 1", cnt_en); end
        set_in(1'b0, CMD_START, 8'h00, 1'b1);
        checks++; if ({cnt_b, cnt_a, cnt_en} !== 9'h132) begin errors++; $display("FAIL clrload_lim99 got %h want 132", {cnt_b, cnt_a, cnt_en}); end
        set_in(1'b0, CMD_START, 8'h00, 1'b0);
        checks++; if ({done, running} !== 2'b10) begin errors++; $display("FAIL clrload_done got %b want 10", {done, running}); end
    endtask

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = CMD_START;
        cif.cmd_data  = 8'h00;
        test_reset();
        test_stop_mode();
        test_done_restart();
        test_stop_tick();
        test_wrap();
        test_preset();
        test_sanitise_limit();
        test_clear_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
